// File: rtl/arbiter_rr_4ph_sync.sv
`timescale 1ns/1ps
// arbiter_rr_4ph_sync
// Clocked N-way mutual-exclusion arbiter for single-rail 4-phase (return-to-zero)
// channels. N independent clients compete for one shared downstream channel
// r0/a0. Every request line and the downstream ack pass through SYNC_STAGES
// flops before the FSM looks at them, so producers and the consumer may sit in
// other timing domains. Winner selection is round-robin (PRIO_MODE=0) or fixed
// priority with the lowest index winning (PRIO_MODE=1).
module arbiter_rr_4ph_sync #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PRIO_MODE   = 0,
  localparam int IW         = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  r,
  output logic [N-1:0]  a,
  output logic          r0,
  input  logic          a0,
  output logic [IW-1:0] gnt_idx,
  output logic          busy,
  output logic          proto_err
);

  // Handshake phases of the shared channel
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] RTZ  = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_next;
  logic [N-1:0]  r_s;
  logic          a0_s;
  logic          win_valid;
  logic [IW-1:0] win_idx;
  logic [IW:0]   cand_sum;
  logic [N-1:0]  gnt_onehot;

  // Synchroniser chain; with zero stages the inputs are used directly
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign r_s  = r;
      assign a0_s = a0;
    end else begin : g_sync
      logic [N:0] sync_q [SYNC_STAGES];

      // Shift the downstream ack and all client requests through the chain together
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
          end
        end else begin
          sync_q[0] <= {a0, r};
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign r_s  = sync_q[SYNC_STAGES-1][N-1:0];
      assign a0_s = sync_q[SYNC_STAGES-1][N];
    end
  endgenerate

  // Pick the first pending client, scanning upward from the pointer with
  // wrap-around in round-robin mode, or from index 0 in fixed-priority mode
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    for (int k = 0; k < N; k++) begin
      if (PRIO_MODE != 0) begin
        cand_sum = (IW+1)'(k);
      end else begin
        cand_sum = {1'b0, ptr} + (IW+1)'(k);
        if (cand_sum >= (IW+1)'(N)) begin
          cand_sum = cand_sum - (IW+1)'(N);
        end
      end
      if (!win_valid && r_s[cand_sum[IW-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand_sum[IW-1:0];
      end
    end
  end

  // The client after the last winner gets first look at the next arbitration
  assign ptr_next = (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + 1'b1;

  assign gnt_onehot = N'(1) << gnt_idx;

  // Any state other than IDLE means the downstream channel is owned
  assign busy = (state != IDLE);

  // Main handshake FSM: at most one transition per clock edge; gnt_idx
  // keeps the last winner through IDLE so it can be read after completion
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      a         <= '0;
      r0        <= 1'b0;
      gnt_idx   <= '0;
      ptr       <= '0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (a0_s) begin
            proto_err <= 1'b1;
          end
          if (win_valid) begin
            gnt_idx <= win_idx;
            r0      <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (!r_s[gnt_idx]) begin
            proto_err <= 1'b1;
          end
          if (a0_s) begin
            a     <= gnt_onehot;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (!r_s[gnt_idx]) begin
            r0    <= 1'b0;
            state <= RTZ;
          end
        end
        RTZ: begin
          if (!a0_s) begin
            a     <= '0;
            state <= IDLE;
            if (PRIO_MODE == 0) begin
              ptr <= ptr_next;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter_rr_4ph_sync.sv
`timescale 1ns/1ps
// Testbench for arbiter_rr_4ph_sync: one round-robin and one fixed-priority
// instance (N=4, two synchroniser stages), downstream ack echoing r0 after 12ns.
module tb_arbiter_rr_4ph_sync;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic [N-1:0] r_rr, a_rr, r_fx, a_fx;
  logic         r0_rr, r0_fx, a0_rr, a0_fx;
  logic         a0_rr_echo, a0_fx_echo, a0_force;
  logic [1:0]   gnt_rr, gnt_fx;
  logic         busy_rr, busy_fx, perr_rr, perr_fx;

  int checks = 0;
  int passes = 0;

  logic         chk_en;
  logic         model_en;
  int           model_ptr;
  int           m_exp;
  longint       m_cut;
  longint       rise_t [N];
  int           grant_log [$];
  logic [N-1:0] a_rr_q, a_fx_q;
  logic         r0_rr_q;

  typedef struct {
    logic [3:0] req;
    logic [1:0] exp_rr;
    logic [1:0] exp_fx;
  } vec_t;

  vec_t vecs [10];

  // 10ns clock
  always #5 clk = ~clk;

  // Downstream consumer: ack follows request after 12ns; a0_force injects a stray ack
  assign #12 a0_rr_echo = r0_rr;
  assign #12 a0_fx_echo = r0_fx;
  assign a0_rr = a0_rr_echo | a0_force;
  assign a0_fx = a0_fx_echo;

  arbiter_rr_4ph_sync #(.N(N), .SYNC_STAGES(2), .PRIO_MODE(0)) dut_rr (
    .clk(clk), .rstn(rstn), .r(r_rr), .a(a_rr), .r0(r0_rr), .a0(a0_rr),
    .gnt_idx(gnt_rr), .busy(busy_rr), .proto_err(perr_rr)
  );

  arbiter_rr_4ph_sync #(.N(N), .SYNC_STAGES(2), .PRIO_MODE(1)) dut_fx (
    .clk(clk), .rstn(rstn), .r(r_fx), .a(a_fx), .r0(r0_fx), .a0(a0_fx),
    .gnt_idx(gnt_fx), .busy(busy_fx), .proto_err(perr_fx)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  // 4-phase protocol watch on every channel plus the round-robin reference model.
  // The model works from request timestamps: a client counts as visible to the
  // arbiter at a decision edge only if it raised its request before the edge two
  // clocks earlier, and the winner is the first visible client from the pointer.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      checkOutput("onehot_rr", 32'($countones(a_rr) <= 1), 32'd1);
      checkOutput("onehot_fx", 32'($countones(a_fx) <= 1), 32'd1);
      if (a_rr != '0) checkOutput("ack_only_when_busy", 32'(busy_rr), 32'd1);
      for (int i = 0; i < N; i++) begin
        if (a_rr[i] && !a_rr_q[i]) checkOutput("rr_ack_rise_needs_req", 32'(r_rr[i]), 32'd1);
        if (!a_rr[i] && a_rr_q[i]) checkOutput("rr_ack_fall_needs_release", 32'(r_rr[i]), 32'd0);
        if (a_fx[i] && !a_fx_q[i]) checkOutput("fx_ack_rise_needs_req", 32'(r_fx[i]), 32'd1);
        if (!a_fx[i] && a_fx_q[i]) checkOutput("fx_ack_fall_needs_release", 32'(r_fx[i]), 32'd0);
      end
      if (r0_rr && !r0_rr_q) checkOutput("r0_rise_needs_a0_low", 32'(a0_rr), 32'd0);
      if (!r0_rr && r0_rr_q) checkOutput("r0_fall_needs_a0_high", 32'(a0_rr), 32'd1);
    end
    if (model_en && r0_rr && !r0_rr_q) begin
      m_exp = -1;
      m_cut = longint'($time) - 21;
      for (int k = 0; k < N; k++) begin
        if (m_exp < 0 && r_rr[(model_ptr + k) % N] && rise_t[(model_ptr + k) % N] < m_cut)
          m_exp = (model_ptr + k) % N;
      end
      checkOutput("rr_winner", 32'(gnt_rr), 32'(m_exp));
      grant_log.push_back(int'(gnt_rr));
      if (m_exp >= 0) model_ptr = (m_exp + 1) % N;
    end
    a_rr_q  = a_rr;
    a_fx_q  = a_fx;
    r0_rr_q = r0_rr;
  end

  // Selectable conditions for the latency measurements on client 2
  function automatic logic lat_cond(input int sel);
    case (sel)
      0:       return r0_rr;
      1:       return a_rr[2];
      2:       return !r0_rr;
      3:       return !a_rr[2];
      default: return 1'b1;
    endcase
  endfunction

  // Count rising edges until the selected condition holds (bounded)
  task automatic count_edges(input int sel, output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!lat_cond(sel) && n < 30);
  endtask

  // Wait for the echoed downstream ack to reach a level (bounded)
  task automatic wait_a0(input logic val);
    for (int t = 0; t < 100 && a0_rr !== val; t++) #1;
  endtask

  // Wait until one instance shows any ack (want=1) or no ack (want=0)
  task automatic wait_ack(input int inst, input logic want, output logic ok);
    ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      if (((inst == 0 ? a_rr : a_fx) != '0) == want) ok = 1'b1;
    end
  endtask

  // Wait until both instances are back in IDLE with all acks low
  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      if (!busy_rr && !busy_fx && a_rr == '0 && a_fx == '0) ok = 1'b1;
    end
    checkOutput(name, 32'(ok), 32'd1);
  endtask

  // Reset both instances and clear all stimulus
  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; r_rr = '0; r_fx = '0; a0_force = 1'b0; model_ptr = 0;
    repeat (4) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Present one request pattern to both instances, check the winners, then release
  task automatic applyStimulus(input vec_t v);
    logic ok;
    @(negedge clk);
    r_rr = v.req; r_fx = v.req;
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (a_rr != '0 && a_fx != '0) ok = 1'b1;
    end
    checkOutput("vec_grant_timeout", 32'(ok), 32'd1);
    checkOutput("vec_gnt_rr", 32'(gnt_rr), 32'(v.exp_rr));
    checkOutput("vec_ack_rr", 32'(a_rr), 32'd1 << v.exp_rr);
    checkOutput("vec_gnt_fx", 32'(gnt_fx), 32'(v.exp_fx));
    checkOutput("vec_ack_fx", 32'(a_fx), 32'd1 << v.exp_fx);
    r_rr = '0; r_fx = '0;
    wait_idle("vec_idle_timeout");
    checkOutput("vec_gnt_hold_rr", 32'(gnt_rr), 32'(v.exp_rr));
  endtask

  // Cycle-stepped client population on the round-robin instance: each client
  // waits a random delay, requests, drops on ack, then waits for ack to fall
  task automatic run_clients(input int target, input int max_delay, input int budget);
    int st [N];
    int dly [N];
    int launched, done, cyc;
    launched = 0; done = 0; cyc = 0;
    for (int i = 0; i < N; i++) begin
      st[i] = 0; dly[i] = int'($urandom_range(max_delay, 0));
    end
    while (done < target && cyc < budget) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
        case (st[i])
          0: if (launched < target) begin
               if (dly[i] == 0) begin
                 r_rr[i] = 1'b1; rise_t[i] = longint'($time); launched++; st[i] = 1;
               end else dly[i]--;
             end
          1: if (a_rr[i]) begin r_rr[i] = 1'b0; st[i] = 2; end
          2: if (!a_rr[i]) begin
               done++; st[i] = 0; dly[i] = int'($urandom_range(max_delay, 0));
             end
          default: st[i] = 0;
        endcase
      end
    end
    checkOutput("handshakes_done", 32'(done), 32'(target));
  endtask

  // Main sequence
  initial begin
    int n;
    logic ok;
    rstn = 1'b0; r_rr = '1; r_fx = '1; a0_force = 1'b0;
    chk_en = 1'b0; model_en = 1'b0; model_ptr = 0;
    for (int i = 0; i < N; i++) rise_t[i] = 0;

    vecs[0] = '{4'b1111, 2'd0, 2'd0};
    vecs[1] = '{4'b1111, 2'd1, 2'd0};
    vecs[2] = '{4'b0001, 2'd0, 2'd0};
    vecs[3] = '{4'b1010, 2'd1, 2'd1};
    vecs[4] = '{4'b1010, 2'd3, 2'd1};
    vecs[5] = '{4'b0100, 2'd2, 2'd2};
    vecs[6] = '{4'b0011, 2'd0, 2'd0};
    vecs[7] = '{4'b1100, 2'd2, 2'd2};
    vecs[8] = '{4'b1001, 2'd3, 2'd0};
    vecs[9] = '{4'b0110, 2'd1, 2'd1};

    // Reset released with every client requesting
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    #1;
    checkOutput("reset_a_rr", 32'(a_rr), 32'd0);
    checkOutput("reset_r0_rr", 32'(r0_rr), 32'd0);
    checkOutput("reset_busy_rr", 32'(busy_rr), 32'd0);
    checkOutput("reset_gnt_rr", 32'(gnt_rr), 32'd0);
    checkOutput("reset_perr_rr", 32'(perr_rr), 32'd0);
    checkOutput("reset_a_fx", 32'(a_fx), 32'd0);
    checkOutput("reset_busy_fx", 32'(busy_fx), 32'd0);
    chk_en = 1'b1;

    // Table of request patterns; the first row confirms client 0 wins after reset
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);
    checkOutput("table_perr_rr", 32'(perr_rr), 32'd0);
    checkOutput("table_perr_fx", 32'(perr_fx), 32'd0);

    // Single request latencies with two synchroniser stages
    @(negedge clk);
    r_rr = 4'b0100;
    count_edges(0, n);
    checkOutput("lat_r0_rise", 32'(n), 32'd3);
    checkOutput("single_gnt", 32'(gnt_rr), 32'd2);
    wait_a0(1'b1);
    count_edges(1, n);
    checkOutput("lat_ack_rise", 32'(n), 32'd3);
    @(negedge clk);
    r_rr = 4'b0000;
    count_edges(2, n);
    checkOutput("lat_r0_fall", 32'(n), 32'd3);
    wait_a0(1'b0);
    count_edges(3, n);
    checkOutput("lat_ack_fall", 32'(n), 32'd3);
    checkOutput("single_busy_after", 32'(busy_rr), 32'd0);
    wait_idle("single_idle_timeout");

    // Fixed priority: client 1 beats client 3, which waits until 1 completes
    @(negedge clk);
    r_fx = 4'b1010;
    wait_ack(1, 1'b1, ok);
    checkOutput("fx_first_timeout", 32'(ok), 32'd1);
    checkOutput("fx_first_ack", 32'(a_fx), 32'b0010);
    checkOutput("fx_first_gnt", 32'(gnt_fx), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("fx_client3_waits", 32'(a_fx[3]), 32'd0);
    r_fx = 4'b1000;
    wait_ack(1, 1'b0, ok);
    wait_ack(1, 1'b1, ok);
    checkOutput("fx_second_timeout", 32'(ok), 32'd1);
    checkOutput("fx_second_ack", 32'(a_fx), 32'b1000);
    checkOutput("fx_second_gnt", 32'(gnt_fx), 32'd3);
    r_fx = 4'b0000;
    wait_idle("fx_idle_timeout");

    // Reset in the middle of a handshake drops everything at once
    @(negedge clk);
    r_rr = 4'b0001;
    wait_ack(0, 1'b1, ok);
    checkOutput("midrst_hold_timeout", 32'(ok), 32'd1);
    chk_en = 1'b0;
    #2 rstn = 1'b0;
    #1;
    checkOutput("midrst_a", 32'(a_rr), 32'd0);
    checkOutput("midrst_r0", 32'(r0_rr), 32'd0);
    checkOutput("midrst_busy", 32'(busy_rr), 32'd0);
    checkOutput("midrst_perr", 32'(perr_rr), 32'd0);
    r_rr = '0;
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    model_ptr = 0;
    repeat (5) @(negedge clk);
    checkOutput("midrst_perr_after", 32'(perr_rr), 32'd0);

    // Stray downstream ack while idle sets the sticky error flag
    a0_force = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("stray_a0_perr", 32'(perr_rr), 32'd1);
    checkOutput("stray_a0_busy", 32'(busy_rr), 32'd0);
    a0_force = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("stray_a0_sticky", 32'(perr_rr), 32'd1);
    do_reset();
    #1;
    checkOutput("perr_cleared_by_reset", 32'(perr_rr), 32'd0);

    // Request withdrawn while REQ: flagged, but the handshake still completes
    @(negedge clk);
    r_rr = 4'b0010;
    count_edges(0, n);
    @(negedge clk);
    r_rr = 4'b0000;
    wait_ack(0, 1'b1, ok);
    checkOutput("drop_req_ack_timeout", 32'(ok), 32'd1);
    checkOutput("drop_req_ack", 32'(a_rr), 32'b0010);
    wait_idle("drop_req_idle_timeout");
    checkOutput("drop_req_perr", 32'(perr_rr), 32'd1);

    // Round-robin fairness with all clients re-requesting straight away
    do_reset();
    chk_en = 1'b1;
    grant_log.delete();
    model_en = 1'b1;
    run_clients(8, 0, 400);
    checkOutput("fair_grant_count", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      checkOutput("fair_order", 32'(grant_log[i]), 32'(i % N));

    // Randomised traffic against the reference model
    model_en = 1'b0;
    do_reset();
    model_en = 1'b1;
    run_clients(2000, 20, 60000);
    model_en = 1'b0;
    wait_idle("random_idle_timeout");
    checkOutput("random_perr", 32'(perr_rr), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
